// File: rtl/stim_driver_pkg.sv
// Shared types and constants for the stim_driver slice: FSM states, LFSR and MISR
// widths/taps, and their next-value helpers.
package stim_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int                LFSR_W    = 4;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1001;
    localparam int                MISR_W    = 8;
    localparam logic [MISR_W-1:0] MISR_TAPS = 8'b1011_1000;
    localparam int                SIG_W     = 8;
    localparam int                RESP_W    = 3;
    localparam int                CNT_W     = 8;

    // Shift left, feedback bit is the XOR of the tapped bits (3 and 0 -> period 15).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                    input logic [RESP_W-1:0] d);
        return {s[MISR_W-2:0], ^(s & MISR_TAPS)} ^ {{(MISR_W-RESP_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/stim_misr.sv
// Response signature register (MISR). Instantiated by stim_driver only when
// STIM_DRIVER_MISR_EN is defined.
module stim_misr
    import stim_driver_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [RESP_W-1:0] i_data,
    output logic [SIG_W-1:0]  o_sig
);

    logic [MISR_W-1:0] r_sig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/stim_driver.sv
// LFSR stimulus driver with a latency-matched capture pipeline and optional
// response signature (enabled by the STIM_DRIVER_MISR_EN macro).
module stim_driver
    import stim_driver_pkg::*;
#(
    parameter int                VEC_COUNT = 16,   // 1..255
    parameter int                LATENCY   = 2,    // 1..4
    parameter logic [LFSR_W-1:0] SEED      = 4'h1  // nonzero
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic              ABORT,
    input  logic [RESP_W-1:0] S_IN,
    output logic [LFSR_W-1:0] I_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              CAP_VALID,
    output logic [SIG_W-1:0]  SIG,
    output state_e            o_dbg_state,
    output logic [RESP_W-1:0] o_dbg_resp
);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(VEC_COUNT);
    localparam logic [2:0]       DRAIN_LAST = 3'(LATENCY - 1);

    state_e              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   r_iout;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_drain;
    logic [LATENCY-1:0]  r_vpipe;
    logic                r_busy;
    logic                r_done;
    logic                r_cap;
    logic [RESP_W-1:0]   r_resp;

    logic                w_start;
    logic                w_issue;
    logic                w_capture;

    assign w_start   = START && !ABORT && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_issue   = !ABORT && (w_start || ((r_state == ST_RUN) && (r_cnt < CNT_MAX)));
    assign w_capture = r_vpipe[LATENCY-1] && !ABORT;

    // r_lfsr always equals the vector being presented on I_OUT during RUN.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED;
            r_iout  <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (ABORT) begin
            r_state <= ST_IDLE;
            r_iout  <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        r_state <= ST_RUN;
                        r_lfsr  <= SEED;
                        r_iout  <= SEED;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt < CNT_MAX) begin
                        r_lfsr <= lfsr_next(r_lfsr);
                        r_iout <= lfsr_next(r_lfsr);
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state <= ST_DRAIN;
                        r_iout  <= '0;
                        r_drain <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_iout  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // CAP_VALID is a valid-only strobe (no ready): it is high for the one cycle
    // after S_IN was sampled, aligned with the updated SIG.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_vpipe <= '0;
            r_cap   <= 1'b0;
            r_resp  <= '0;
        end else if (ABORT) begin
            r_vpipe <= '0;
            r_cap   <= 1'b0;
        end else begin
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_cap <= w_capture;
            if (w_capture) begin
                r_resp <= S_IN;
            end
        end
    end

`ifdef STIM_DRIVER_MISR_EN
    logic [SIG_W-1:0] w_sig;

    stim_misr u_misr (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_clr   (w_start),
        .i_en    (w_capture),
        .i_data  (S_IN),
        .o_sig   (w_sig)
    );

    assign SIG = w_sig;
`else
    assign SIG = '0;
`endif

    assign I_OUT       = r_iout;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign CAP_VALID   = r_cap;
    assign o_dbg_state = r_state;
    assign o_dbg_resp  = r_resp;

endmodule
